// File: rtl/svo_tmds_period_seq.sv
// Period scheduler for the three svo_tmds encoders of one HDMI link: delays video by LEAD clocks
// and inserts the video preamble and leading guard band in that time. HDMI build: SVO_TMDS_SEQ_HDMI_EN.
module svo_tmds_period_seq #(
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2,
    parameter int ENC_LATENCY  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_de,
    input  logic       in_hsync,
    input  logic       in_vsync,
    input  logic [7:0] in_r,
    input  logic [7:0] in_g,
    input  logic [7:0] in_b,
    output logic       enc_de,
    output logic [1:0] enc_ctrl0,
    output logic [1:0] enc_ctrl1,
    output logic [1:0] enc_ctrl2,
    output logic [7:0] enc_din0,
    output logic [7:0] enc_din1,
    output logic [7:0] enc_din2,
    output logic       ovr_en,
    output logic [9:0] ovr_sym0,
    output logic [9:0] ovr_sym1,
    output logic [9:0] ovr_sym2,
    output logic       short_gap_err
);
    localparam int LEAD = PREAMBLE_LEN + GUARD_LEN;
    localparam int DL_W = 27;

    if (PREAMBLE_LEN < 1 || GUARD_LEN < 1 || ENC_LATENCY < 1) begin : g_bad_param
        $error("svo_tmds_period_seq: PREAMBLE_LEN, GUARD_LEN and ENC_LATENCY must be >= 1");
    end

    logic [DL_W-1:0] dl_q [LEAD];
    logic            d_de, d_vsync, d_hsync;
    logic [7:0]      d_r, d_g, d_b;
    logic            enc_de_q;
    logic [1:0]      enc_ctrl0_q;
    logic [7:0]      enc_din0_q, enc_din1_q, enc_din2_q;

    assign {d_de, d_vsync, d_hsync, d_r, d_g, d_b} = dl_q[LEAD-1];

    // Video delay line: LEAD stages, then the encoder-facing output register
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LEAD; k++) dl_q[k] <= '0;
            enc_de_q    <= 1'b0;
            enc_ctrl0_q <= 2'b00;
            enc_din0_q  <= 8'h00;
            enc_din1_q  <= 8'h00;
            enc_din2_q  <= 8'h00;
        end else begin
            dl_q[0] <= {in_de, in_vsync, in_hsync, in_r, in_g, in_b};
            for (int k = 1; k < LEAD; k++) dl_q[k] <= dl_q[k-1];
            enc_de_q    <= d_de;
            enc_ctrl0_q <= {d_vsync, d_hsync};
            enc_din0_q  <= d_de ? d_b : 8'h00;
            enc_din1_q  <= d_de ? d_g : 8'h00;
            enc_din2_q  <= d_de ? d_r : 8'h00;
        end
    end

    assign enc_de    = enc_de_q;
    assign enc_ctrl0 = enc_ctrl0_q;
    assign enc_din0  = enc_din0_q;
    assign enc_din1  = enc_din1_q;
    assign enc_din2  = enc_din2_q;
    assign enc_ctrl2 = 2'b00;

`ifdef SVO_TMDS_SEQ_HDMI_EN
    typedef enum logic [1:0] {IDLE, PRE, GB} state_t;

    localparam int GAP_W   = $clog2(LEAD + 1);
    localparam int CNT_MAX = (PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [9:0] GB_SYM_02 = 10'b1011001100;
    localparam logic [9:0] GB_SYM_1  = 10'b0100110011;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               err_q, err_d;
    logic               ctrl1_q, gb_q;
    logic [ENC_LATENCY-1:0] ovr_pipe_q;
    logic [ENC_LATENCY:0]   ovr_tap;
    logic [9:0]         sym02_q, sym1_q;
    logic               de_prev, rise, fall;

    // The first delay stage doubles as the previous-cycle in_de for edge detection
    assign de_prev = dl_q[0][DL_W-1];
    assign rise    = in_de & ~de_prev;
    assign fall    = ~in_de & de_prev;
    assign ovr_tap = {ovr_pipe_q, gb_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        err_d   = err_q;
        if (fall) begin
            gap_d = '0;
        end else if (!in_de && gap_q != GAP_W'(LEAD)) begin
            gap_d = gap_q + GAP_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (rise) begin
                    if (gap_q == GAP_W'(LEAD)) begin
                        state_d = PRE;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PRE: begin
                if (rise) err_d = 1'b1;
                if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
                    state_d = GB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GB: begin
                if (rise) err_d = 1'b1;
                if (cnt_q == CNT_W'(GUARD_LEN - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Period state, then the guard flag delayed to line up with the encoder outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            gap_q      <= GAP_W'(LEAD);
            err_q      <= 1'b0;
            ctrl1_q    <= 1'b0;
            gb_q       <= 1'b0;
            ovr_pipe_q <= '0;
            sym02_q    <= '0;
            sym1_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            err_q      <= err_d;
            ctrl1_q    <= (state_d == PRE);
            gb_q       <= (state_d == GB);
            ovr_pipe_q <= ovr_tap[ENC_LATENCY-1:0];
            sym02_q    <= ovr_tap[ENC_LATENCY-1] ? GB_SYM_02 : 10'd0;
            sym1_q     <= ovr_tap[ENC_LATENCY-1] ? GB_SYM_1 : 10'd0;
        end
    end

    assign enc_ctrl1     = {1'b0, ctrl1_q};
    assign ovr_en        = ovr_pipe_q[ENC_LATENCY-1];
    assign ovr_sym0      = sym02_q;
    assign ovr_sym1      = sym1_q;
    assign ovr_sym2      = sym02_q;
    assign short_gap_err = err_q;
`else
    // DVI: no data-island/preamble periods, encoders only see video and sync
    assign enc_ctrl1     = 2'b00;
    assign ovr_en        = 1'b0;
    assign ovr_sym0      = 10'd0;
    assign ovr_sym1      = 10'd0;
    assign ovr_sym2      = 10'd0;
    assign short_gap_err = 1'b0;
`endif

endmodule

// File: tb/tb_svo_tmds_period_seq.sv
// Self-checking bench for svo_tmds_period_seq: event-level model of line starts, preambles and
// guard bands compared every cycle, plus literal expectations at key cycles. Works in both builds.
module tb_svo_tmds_period_seq;
    localparam int PRE  = 8;
    localparam int GB   = 2;
    localparam int ENC  = 3;
    localparam int LEAD = PRE + GB;
`ifdef SVO_TMDS_SEQ_HDMI_EN
    localparam bit HDMI = 1'b1;
`else
    localparam bit HDMI = 1'b0;
`endif
    localparam int MAXE = 1024;
    localparam logic [9:0] SYM0 = 10'b1011001100;
    localparam logic [9:0] SYM1 = 10'b0100110011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_de = 1'b0, in_hsync = 1'b0, in_vsync = 1'b0;
    logic [7:0] in_r = 8'h00, in_g = 8'h00, in_b = 8'h00;
    logic       enc_de, ovr_en, short_gap_err;
    logic [1:0] enc_ctrl0, enc_ctrl1, enc_ctrl2;
    logic [7:0] enc_din0, enc_din1, enc_din2;
    logic [9:0] ovr_sym0, ovr_sym1, ovr_sym2;

    svo_tmds_period_seq #(.PREAMBLE_LEN(PRE), .GUARD_LEN(GB), .ENC_LATENCY(ENC)) dut (
        .clk(clk), .reset(reset), .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .enc_de(enc_de), .enc_ctrl0(enc_ctrl0), .enc_ctrl1(enc_ctrl1), .enc_ctrl2(enc_ctrl2),
        .enc_din0(enc_din0), .enc_din1(enc_din1), .enc_din2(enc_din2),
        .ovr_en(ovr_en), .ovr_sym0(ovr_sym0), .ovr_sym1(ovr_sym1), .ovr_sym2(ovr_sym2),
        .short_gap_err(short_gap_err)
    );

    always #5 clk = ~clk;

    int n = 0;
    int n_checks = 0;
    int n_err = 0;

    bit       hist_de [MAXE];
    bit       hist_hs [MAXE];
    bit       hist_vs [MAXE];
    bit [7:0] hist_r [MAXE];
    bit [7:0] hist_g [MAXE];
    bit [7:0] hist_b [MAXE];
    bit       gb_m [MAXE];
    int       last_one = -1000;
    int       seq_start = -1000;
    int       last_reset = 0;
    bit       err_m = 1'b0;

    logic       obs_de [MAXE];
    logic [1:0] obs_ctrl0 [MAXE];
    logic [1:0] obs_ctrl1 [MAXE];
    logic [7:0] obs_din0 [MAXE];
    logic [7:0] obs_din1 [MAXE];
    logic [7:0] obs_din2 [MAXE];
    logic       obs_ovr [MAXE];
    logic [9:0] obs_sym0 [MAXE];
    logic [9:0] obs_sym1 [MAXE];
    logic       obs_err [MAXE];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (edge %0d): got %0h, expected %0h", nm, n, act, exp);
        end
    endfunction

    // Model: a line start is a sampled in_de rise; it gets preamble+guard on the next LEAD output
    // cycles if no sequence is running and at least LEAD+1 blank samples preceded it.
    always @(posedge clk) begin : compare
        bit rise, busy, gap_ok;
        int pos, s;
        bit e_de, e_ovr;
        bit [1:0] e_ctrl0, e_ctrl1;
        bit [7:0] e_d0, e_d1, e_d2;
        n++;
        if (reset) begin
            hist_de[n] = 0; hist_hs[n] = 0; hist_vs[n] = 0;
            hist_r[n] = 0; hist_g[n] = 0; hist_b[n] = 0;
            last_one = -1000;
            seq_start = -1000;
            err_m = 1'b0;
            last_reset = n;
        end else begin
            hist_de[n] = in_de; hist_hs[n] = in_hsync; hist_vs[n] = in_vsync;
            hist_r[n] = in_r; hist_g[n] = in_g; hist_b[n] = in_b;
            rise   = in_de && !hist_de[n-1];
            busy   = (n - 1 >= seq_start) && (n - 1 <= seq_start + LEAD - 1);
            gap_ok = (n - last_one - 2) >= LEAD;
            if (rise) begin
                if (!busy && gap_ok) seq_start = n;
                else err_m = 1'b1;
            end
            if (in_de) last_one = n;
        end
        pos = n - seq_start;
        gb_m[n] = HDMI && !reset && pos >= PRE && pos < LEAD;
        e_ctrl1 = {1'b0, HDMI && !reset && pos >= 0 && pos < PRE};
        s = n - LEAD;
        e_de    = (s > last_reset) ? hist_de[s] : 1'b0;
        e_ctrl0 = (s > last_reset) ? {hist_vs[s], hist_hs[s]} : 2'b00;
        e_d0    = e_de ? hist_b[s] : 8'h00;
        e_d1    = e_de ? hist_g[s] : 8'h00;
        e_d2    = e_de ? hist_r[s] : 8'h00;
        e_ovr   = (n - ENC > last_reset) ? gb_m[n-ENC] : 1'b0;
        #1;
        obs_de[n] = enc_de; obs_ctrl0[n] = enc_ctrl0; obs_ctrl1[n] = enc_ctrl1;
        obs_din0[n] = enc_din0; obs_din1[n] = enc_din1; obs_din2[n] = enc_din2;
        obs_ovr[n] = ovr_en; obs_sym0[n] = ovr_sym0; obs_sym1[n] = ovr_sym1;
        obs_err[n] = short_gap_err;
        chk("enc_de", enc_de, e_de);
        chk("enc_ctrl0", enc_ctrl0, e_ctrl0);
        chk("enc_ctrl1", enc_ctrl1, e_ctrl1);
        chk("enc_ctrl2", enc_ctrl2, 2'b00);
        chk("enc_din0", enc_din0, e_d0);
        chk("enc_din1", enc_din1, e_d1);
        chk("enc_din2", enc_din2, e_d2);
        chk("ovr_en", ovr_en, e_ovr);
        chk("ovr_sym0", ovr_sym0, e_ovr ? SYM0 : 10'd0);
        chk("ovr_sym1", ovr_sym1, e_ovr ? SYM1 : 10'd0);
        chk("ovr_sym2", ovr_sym2, e_ovr ? SYM0 : 10'd0);
        chk("short_gap_err", short_gap_err, HDMI && err_m);
    end

    task automatic drive(input logic rst, input logic de, input logic hs, input logic vs,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input int cycles, output int first_e);
        first_e = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (i == 0) first_e = n + 1;
            reset = rst; in_de = de; in_hsync = hs; in_vsync = vs;
            in_r = r; in_g = g; in_b = b;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int tmp, t2, ta, tb, tc, td, tr;
        // Reset with active video and all-ones data
        drive(1, 1, 1, 1, 8'hFF, 8'hFF, 8'hFF, 3, tmp);
        drive(0, 0, 0, 0, 8'h55, 8'hAA, 8'h5A, 20, tmp);
        drive(0, 1, 0, 0, 8'h01, 8'h02, 8'h03, 4, t2);
        drive(0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 5, tmp);
        drive(0, 0, 1, 0, 8'h11, 8'h22, 8'h33, 20, tmp);
        // Two lines with a 6-clk gap
        drive(0, 1, 0, 0, 8'h10, 8'h20, 8'h30, 4, ta);
        drive(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 6, tmp);
        drive(0, 1, 0, 0, 8'h40, 8'h50, 8'h60, 4, tb);
        drive(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 30, tmp);
        // hsync toggled during the preamble
        drive(0, 1, 0, 0, 8'h71, 8'h72, 8'h73, 2, tc);
        drive(0, 1, 1, 0, 8'h74, 8'h75, 8'h76, 2, tmp);
        drive(0, 1, 0, 0, 8'h77, 8'h78, 8'h79, 1, tmp);
        drive(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 12, tmp);
        // Single-clock line
        drive(0, 1, 0, 0, 8'hAA, 8'hBB, 8'hCC, 1, td);
        drive(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 20, tmp);
        // Reset in the middle of a line
        drive(0, 1, 0, 0, 8'h99, 8'h88, 8'h77, 3, tr);
        drive(1, 1, 0, 0, 8'h99, 8'h88, 8'h77, 2, tmp);
        drive(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 25, tmp);

        chk("rst_enc_de", obs_de[4], 1'b0);
        chk("rst_enc_din0", obs_din0[4], 8'h00);
        chk("rst_enc_din2", obs_din2[4], 8'h00);
        chk("rst_err", obs_err[5], 1'b0);

        chk("l1_ctrl1_t", obs_ctrl1[t2], {1'b0, HDMI});
        chk("l1_ctrl1_t7", obs_ctrl1[t2+7], {1'b0, HDMI});
        chk("l1_ctrl1_t8", obs_ctrl1[t2+8], 2'b00);
        chk("l1_ovr_t10", obs_ovr[t2+10], 1'b0);
        chk("l1_ovr_t11", obs_ovr[t2+11], HDMI);
        chk("l1_sym0_t11", obs_sym0[t2+11], HDMI ? SYM0 : 10'd0);
        chk("l1_sym1_t12", obs_sym1[t2+12], HDMI ? SYM1 : 10'd0);
        chk("l1_ovr_t13", obs_ovr[t2+13], 1'b0);
        chk("l1_de_t9", obs_de[t2+9], 1'b0);
        chk("l1_de_t10", obs_de[t2+10], 1'b1);
        chk("l1_din2_t10", obs_din2[t2+10], 8'h01);
        chk("l1_din1_t10", obs_din1[t2+10], 8'h02);
        chk("l1_din0_t10", obs_din0[t2+10], 8'h03);
        chk("l1_de_t13", obs_de[t2+13], 1'b1);
        chk("l1_de_t14", obs_de[t2+14], 1'b0);

        chk("gap_ctrl1_b2", obs_ctrl1[tb+2], 2'b00);
        chk("gap_de_b10", obs_de[tb+LEAD], 1'b1);
        chk("gap_din2_b10", obs_din2[tb+LEAD], 8'h40);
        chk("gap_err_before", obs_err[tb-1], 1'b0);
        chk("gap_err_set", obs_err[tb], HDMI);
        chk("gap_err_sticky", obs_err[tc+5], HDMI);

        chk("hs_ctrl0_pre", obs_ctrl0[tc+1+LEAD], 2'b00);
        chk("hs_ctrl0_follow", obs_ctrl0[tc+2+LEAD], 2'b01);
        chk("hs_ctrl1", obs_ctrl1[tc+2], {1'b0, HDMI});

        chk("pulse_ctrl1_t", obs_ctrl1[td], {1'b0, HDMI});
        chk("pulse_ctrl1_t10", obs_ctrl1[td+10], 2'b00);
        chk("pulse_de_t10", obs_de[td+10], 1'b1);
        chk("pulse_de_t11", obs_de[td+11], 1'b0);
        chk("pulse_ovr_t12", obs_ovr[td+12], HDMI);

        chk("mid_rst_de_a", obs_de[tr+LEAD], 1'b0);
        chk("mid_rst_de_b", obs_de[tr+LEAD+2], 1'b0);
        chk("mid_rst_err", obs_err[tr+3], 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
